// File: rtl/alu_vec.sv
// Lane-parallel vector ALU: one opcode applied independently to every element-wide
// lane of two packed operands, with a single registered output stage.
module alu_vec #(
  parameter int vector_size = 256,
  parameter int element     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [vector_size-1:0] vectorA,
  input  logic [vector_size-1:0] vectorB,
  input  logic [2:0]             opcode,
  output logic [vector_size-1:0] result
);

  localparam int LANES = vector_size / element;
  localparam int SH    = (element > 1) ? $clog2(element) : 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_e;

  if ((vector_size % element) != 0) begin : g_bad_geometry
    $error("alu_vec: vector_size (%0d) must be a multiple of element (%0d)",
           vector_size, element);
  end

  logic [vector_size-1:0] w_result;
  logic [vector_size-1:0] r_result;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [element-1:0] w_a;
      logic [element-1:0] w_b;
      logic [SH-1:0]      w_sh;
      logic [element-1:0] w_lane;

      assign w_a  = vectorA[gi*element +: element];
      assign w_b  = vectorB[gi*element +: element];
      // Only the low log2(element) bits of b form the shift amount.
      assign w_sh = w_b[SH-1:0];

      // Every operation is evaluated at lane width, so carries and the upper
      // product half never reach the neighbouring lane.
      always_comb begin
        w_lane = '0;
        case (op_e'(opcode))
          OP_ADD:  w_lane = w_a + w_b;
          OP_SUB:  w_lane = w_a - w_b;
          OP_MUL:  w_lane = w_a * w_b;
          OP_AND:  w_lane = w_a & w_b;
          OP_OR:   w_lane = w_a | w_b;
          OP_XOR:  w_lane = w_a ^ w_b;
          OP_SLL:  w_lane = w_a << w_sh;
          OP_SRL:  w_lane = w_a >> w_sh;
          default: w_lane = '0;
        endcase
      end

      assign w_result[gi*element +: element] = w_lane;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
    end else begin
      r_result <= w_result;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_alu_vec.sv
// Self-checking bench for alu_vec: expected results are queued when stimulus is
// driven and popped for comparison one edge later.
module tb_alu_vec;

  localparam int VS    = 256;
  localparam int EL    = 16;
  localparam int LANES = VS / EL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [VS-1:0] vectorA = '0;
  logic [VS-1:0] vectorB = '0;
  logic [2:0]    opcode  = '0;
  logic [VS-1:0] result;

  logic [VS-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  alu_vec #(.vector_size(VS), .element(EL)) dut (
    .clk     (clk),
    .rst     (rst),
    .vectorA (vectorA),
    .vectorB (vectorB),
    .opcode  (opcode),
    .result  (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [VS-1:0] splat(input logic [EL-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [VS-1:0] rand_vec();
    logic [VS-1:0] v;
    for (int w = 0; w < VS / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model worked at wider precision and truncated to the lane width.
  function automatic logic [VS-1:0] model(input logic [VS-1:0] a, input logic [VS-1:0] b,
                                          input logic [2:0] op);
    logic [VS-1:0] r;
    logic [31:0]   wide;
    logic [15:0]   la, lb;
    int            sh;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      la   = a[l*EL +: EL];
      lb   = b[l*EL +: EL];
      sh   = int'(lb) % EL;
      wide = 32'd0;
      case (op)
        3'd0: wide = {16'd0, la} + {16'd0, lb};
        3'd1: wide = 32'h0001_0000 + {16'd0, la} - {16'd0, lb};
        3'd2: wide = {16'd0, la} * {16'd0, lb};
        3'd3: wide = {16'd0, la & lb};
        3'd4: wide = {16'd0, la | lb};
        3'd5: wide = {16'd0, la ^ lb};
        3'd6: wide = {16'd0, la} << sh;
        3'd7: wide = {16'd0, la} >> sh;
        default: wide = 32'd0;
      endcase
      r[l*EL +: EL] = wide[15:0];
    end
    return r;
  endfunction

  // Drive one operation on a falling edge, queue its expected value, and return
  // what the DUT shows just after the following rising edge.
  task automatic step(input logic [VS-1:0] a, input logic [VS-1:0] b, input logic [2:0] op,
                      input logic [VS-1:0] exp_in,
                      output logic [VS-1:0] obs, output logic [VS-1:0] exp_out);
    @(negedge clk);
    vectorA = a;
    vectorB = b;
    opcode  = op;
    exp_q.push_back(exp_in);
    @(posedge clk);
    #1;
    obs     = result;
    exp_out = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [VS-1:0] obs, e;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectorA = rand_vec();
      vectorB = rand_vec();
      opcode  = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      total++;
      if (result !== '0) begin
        bad++;
        $display("FAIL reset_hold: got %h expected 0", result);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    step(splat(16'h0001), splat(16'h0002), 3'b000, splat(16'h0003), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_release_add: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_add_disjoint();
    logic [VS-1:0] a, b, r, obs, e;
    r = {162'd0, {92{1'b1}}, 2'b00};
    a = '0;
    for (int k = 0; k < 94; k++) a[k] = ((93 - k) % 8) < 4;
    a = a & r;
    b = ~a & r;
    step(a, b, 3'b000, r, obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL add_disjoint: got %h expected %h", obs, e);
    end
    step(a, b, 3'b100, r, obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL or_disjoint: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_lane_isolation();
    logic [VS-1:0] obs, e;
    step({240'd0, 16'hFFFF}, {240'd0, 16'h0001}, 3'b000, '0, obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL add_wrap: got %h expected %h", obs, e);
    end
    step('0, {240'd0, 16'h0001}, 3'b001, {240'd0, 16'hFFFF}, obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL sub_wrap: got %h expected %h", obs, e);
    end
    step(splat(16'hFFFF), splat(16'h0001), 3'b000, '0, obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL add_wrap_all: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_mul();
    logic [VS-1:0] obs, e;
    step(splat(16'h0100), splat(16'h0101), 3'b010, splat(16'h0100), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL mul_trunc: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_logic();
    logic [VS-1:0] obs, e;
    step(splat(16'hF0F0), splat(16'hFF00), 3'b011, splat(16'hF000), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL and: got %h expected %h", obs, e);
    end
    step(splat(16'hF0F0), splat(16'hFF00), 3'b101, splat(16'h0FF0), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL xor: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_shift();
    logic [VS-1:0] obs, e;
    step(splat(16'h8001), splat(16'h0011), 3'b110, splat(16'h0002), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL sll: got %h expected %h", obs, e);
    end
    step(splat(16'h8001), splat(16'h0011), 3'b111, splat(16'h4000), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL srl: got %h expected %h", obs, e);
    end
    step(splat(16'hA5C3), splat(16'h0000), 3'b110, splat(16'hA5C3), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL shift_zero: got %h expected %h", obs, e);
    end
    step(splat(16'hFFFF), splat(16'h000F), 3'b110, splat(16'h8000), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL sll_15: got %h expected %h", obs, e);
    end
    step(splat(16'hFFFF), splat(16'h000F), 3'b111, splat(16'h0001), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL srl_15: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_async_reset();
    logic [VS-1:0] obs, e;
    step(splat(16'h1234), splat(16'h1111), 3'b000, splat(16'h2345), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL pre_reset_value: got %h expected %h", obs, e);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (result !== '0) begin
      bad++;
      $display("FAIL async_reset: got %h expected 0", result);
    end
    @(posedge clk);
    #1;
    total++;
    if (result !== '0) begin
      bad++;
      $display("FAIL reset_held_edge: got %h expected 0", result);
    end
    @(negedge clk);
    rst = 1'b1;
    step(splat(16'h0005), splat(16'h0003), 3'b001, splat(16'h0002), obs, e);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL post_reset_sub: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [VS-1:0] a, b, obs, e;
    logic [2:0]    op;
    for (int n = 0; n < 24; n++) begin
      a  = rand_vec();
      b  = rand_vec();
      op = 3'(n % 8);
      step(a, b, op, model(a, b, op), obs, e);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d] op=%0d: got %h expected %h", n, op, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_disjoint();
    test_lane_isolation();
    test_mul();
    test_logic();
    test_shift();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
